// File: rtl/peripheral_mpram_arbiter_axi4.sv
// Round-robin arbiter sharing one single-port MPRAM among NUM_PORTS requesters.
// Grant is combinational from req_i and registered arbitration state; the
// granted port's fields are muxed onto the memory port in the same cycle.
// A locked owner keeps the grant for at most LOCK_MAX consecutive accesses.
// Read responses (rvalid_o) follow a granted read by exactly one cycle.
module peripheral_mpram_arbiter_axi4 #(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LOCK_MAX       = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_PORTS-1:0]                    req_i,
    input  logic [NUM_PORTS-1:0]                    lock_i,
    input  logic [NUM_PORTS-1:0]                    we_i,
    input  logic [NUM_PORTS*(AXI_DATA_WIDTH/8)-1:0] be_i,
    input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]     data_i,
    output logic [NUM_PORTS-1:0]                    gnt_o,
    output logic [NUM_PORTS-1:0]                    rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]               rdata_o,
    output logic                                    mem_req_o,
    output logic                                    mem_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0]             mem_be_o,
    output logic [AXI_ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]               mem_data_o,
    input  logic [AXI_DATA_WIDTH-1:0]               mem_data_i
);

    localparam int BW = AXI_DATA_WIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;

    logic [NUM_PORTS-1:0]  gnt;
    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;

    // Pick the winner: locked owner if it requests, else first requester from rr upward.
    always_comb begin
        int            cand;
        logic [PW-1:0] cand_idx;
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (!rst_i) begin
            if (state_q == ST_LOCKED) begin
                // Owner is exclusive while locked; a dropped owner request idles one cycle.
                if (req_i[owner_q]) begin
                    gnt_any = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    cand     = (int'(rr_q) + i) % NUM_PORTS;
                    cand_idx = PW'(cand);
                    if (!gnt_any && req_i[cand_idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand_idx;
                    end
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Forward the granted port's access to the memory; idle means no write, no byte enables.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (gnt_any) begin
            mem_we_o   = we_i[gnt_idx];
            mem_be_o   = be_i[int'(gnt_idx)*BW +: BW];
            mem_addr_o = addr_i[int'(gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            mem_data_o = data_i[int'(gnt_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    // Next arbitration state: rotate pointer on grants, enter/leave lock, flag reads.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rvalid_d = gnt & ~we_i;
        if (state_q == ST_ARB) begin
            if (gnt_any) begin
                rr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
                if (lock_i[gnt_idx] && (LOCK_MAX > 1)) begin
                    state_d = ST_LOCKED;
                    owner_d = gnt_idx;
                    cnt_d   = CW'(1);
                end
            end
        end else begin
            // rr already points past the owner, so on exit the owner ranks last.
            if (!gnt_any) begin
                state_d = ST_ARB;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (!lock_i[owner_q] || (cnt_d == CW'(LOCK_MAX))) begin
                    state_d = ST_ARB;
                end
            end
        end
    end

    // State registers; reset restores port 0 priority and drops pending responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_ARB;
            rr_q     <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o     = gnt;
    assign mem_req_o = gnt_any;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = mem_data_i;

endmodule

// File: tb/tb_peripheral_mpram_arbiter_axi4.sv
// Bench for peripheral_mpram_arbiter_axi4: table-driven cycle vectors, a few
// hand-written sequences and a randomized run against a behavioural model.
module tb_peripheral_mpram_arbiter_axi4;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int LM = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req, lock, we;
    logic [NP*BW-1:0]  be;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  data;
    logic [NP-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_req, mem_we;
    logic [BW-1:0]     mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    always #5 clk = ~clk;

    peripheral_mpram_arbiter_axi4 #(
        .NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LOCK_MAX(LM)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .be_i(be), .addr_i(addr), .data_i(data), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
    );

    // MPRAM macro: registered read, byte-enabled write.
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    int            m_rr = 0;
    int            m_owner = -1;
    int            m_cnt = 0;
    logic [NP-1:0] m_rv = '0;
    logic [DW-1:0] m_rexp = '0;
    logic [DW-1:0] smem [0:1023];

    function automatic int model_winner();
        if (rst) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] model_gnt();
        logic [NP-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        w = model_winner();
        if (rst) begin
            m_rr = 0; m_owner = -1; m_cnt = 0; m_rv = '0;
        end else begin
            m_rv = '0;
            if (w >= 0) begin
                if (we[w]) begin
                    for (int b = 0; b < BW; b++)
                        if (be[w*BW+b]) smem[addr[w*AW +: AW]][8*b +: 8] = data[w*DW+8*b +: 8];
                end else begin
                    m_rv[w] = 1'b1;
                    m_rexp  = smem[addr[w*AW +: AW]];
                end
            end
            if (m_owner < 0) begin
                if (w >= 0) begin
                    m_rr = (w + 1) % NP;
                    if (lock[w] && LM > 1) begin m_owner = w; m_cnt = 1; end
                end
            end else if (w < 0) begin
                m_owner = -1;
            end else begin
                m_cnt++;
                if (!lock[w] || m_cnt >= LM) m_owner = -1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [NP-1:0] eg;
        int w;
        eg = model_gnt();
        w  = model_winner();
        chk("gnt_model", 32'(gnt), 32'(eg));
        chk("rvalid_model", 32'(rvalid), 32'(m_rv));
        chk("mem_req", 32'(mem_req), 32'(|eg));
        if (m_rv != '0) chk("rdata_model", rdata, m_rexp);
        if (w >= 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(addr[w*AW +: AW]));
            chk("mem_we", 32'(mem_we), 32'(we[w]));
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'd0);
            chk("mem_be_idle", 32'(mem_be), 32'd0);
        end
    endtask

    task automatic set_port(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] b);
        addr[k*AW +: AW] = a;
        data[k*DW +: DW] = d;
        be[k*BW +: BW]   = b;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic [NP-1:0] req, we, lock, gnt, rv;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] w,
                       input logic [NP-1:0] lk, input logic [NP-1:0] g, input logic [NP-1:0] v);
        vec_t e;
        e.rst = r; e.req = rq; e.we = w; e.lock = lk; e.gnt = g; e.rv = v;
        tbl.push_back(e);
    endtask

    logic [NP-1:0] last_g;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  <= 32'hC0DE0000 | 32'(i);
            smem[i]  = 32'hC0DE0000 | 32'(i);
        end
        rst = 1'b1; req = '0; lock = '0; we = '0;
        for (int k = 0; k < NP; k++) set_port(k, AW'(5 + 3*k), 32'h11111111 * 32'(k + 1), '1);
        repeat (2) @(posedge clk);

        // round robin, all reading
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0001);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0010);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0100);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        // write suppressed during reset, then mixed write/read
        add(1, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        // reset right after a granted read
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        // lock held to LOCK_MAX, then rotation and wrap
        add(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        for (int i = 0; i < LM - 1; i++)
            add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 4'b0000);
        add(0, 4'b1001, 4'b1111, 4'b0000, 4'b1000, 4'b0000);
        // lock dropped after third grant
        add(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000);
        // owner drops its request while locked: idle cycle, then others
        add(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b1101, 4'b1111, 4'b0010, 4'b0000, 4'b0000);
        add(0, 4'b1101, 4'b1111, 4'b0000, 4'b0100, 4'b0000);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we; lock = tbl[i].lock;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            model_check();
        end

        // partial byte write at top address, then read back
        @(posedge clk); #1;
        rst = 1'b1; req = '0; we = '0; lock = '0;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0100; we = 4'b0100;
        set_port(2, 10'h3FF, 32'hDEADBEEF, 4'b0011);
        @(negedge clk);
        chk("bw_write_gnt", 32'(gnt), 32'h4);
        chk("bw_write_be", 32'(mem_be), 32'h3);
        model_check();
        @(posedge clk); #1;
        req = 4'b0001; we = 4'b0000;
        set_port(0, 10'h3FF, 32'h0, 4'b1111);
        @(negedge clk);
        chk("bw_read_gnt", 32'(gnt), 32'h1);
        model_check();
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        chk("bw_read_rvalid", 32'(rvalid), 32'h1);
        chk("bw_read_rdata", rdata, 32'hC0DEBEEF);
        model_check();

        // randomized traffic honouring the hold-until-granted rule
        last_g = '1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NP; k++) begin
                if (!req[k] || last_g[k]) begin
                    req[k] = ($urandom_range(0, 2) != 0);
                    we[k]  = $urandom_range(0, 1) == 1;
                    set_port(k, AW'($urandom_range(0, 31)), $urandom(), BW'($urandom_range(0, 15)));
                end
                lock[k] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            model_check();
            last_g = model_gnt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
